// File: rtl/mbus_tx_arbiter.sv
// mbus_tx_arbiter
// Shares the single TX request port of one MBus node among NUM_REQ local
// requesters. Requests are granted round-robin, the winner's address and data
// are captured into registers that feed the node, and a four-phase handshake
// is run on both sides. A watchdog aborts a transfer the node never acks so a
// stuck node cannot lock the requesters out forever.
module mbus_tx_arbiter #(
   parameter int          NUM_REQ = 4,
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NUM_REQ-1:0]    REQ,
   input  logic [8*NUM_REQ-1:0]  ADDR_FLAT,
   input  logic [32*NUM_REQ-1:0] DATA_FLAT,
   output logic [NUM_REQ-1:0]    ACK,
   output logic                  ERR,
   output logic [NUM_REQ-1:0]    GRANT,
   output logic [7:0]            TX_ADDR,
   output logic [31:0]           TX_DATA,
   output logic                  TX_REQ,
   input  logic                  TX_ACK,
   output logic                  BUSY
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_REL,
      DONE
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   next_ptr;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_valid;
   logic [7:0]         sel_addr;
   logic [31:0]        sel_data;
   logic [NUM_REQ-1:0] sel_onehot;
   logic [NUM_REQ-1:0] owner_onehot;
   logic               owner_req;
   logic [15:0]        wd_cnt;
   logic               wd_expired;
   logic               timed_out;

   // Round-robin pick: scan upward from rr_ptr with wrap-around. Iterating the
   // offsets downward and overwriting lets the smallest offset win without a
   // loop exit.
   always_comb begin
      int cand;
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (REQ[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = IDX_W'(cand);
         end
      end
   end

   // Slice out the candidate's address/data and build the one-hot vectors
   // for the candidate and for the current owner.
   always_comb begin
      sel_addr     = ADDR_FLAT[8*int'(sel_idx) +: 8];
      sel_data     = DATA_FLAT[32*int'(sel_idx) +: 32];
      sel_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
      owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
      owner_req    = REQ[owner];
   end

   // Pointer for the next arbitration round: the requester just after the
   // owner that is finishing, wrapping at NUM_REQ.
   always_comb begin
      if (int'(owner) >= NUM_REQ - 1) begin
         next_ptr = '0;
      end else begin
         next_ptr = owner + 1'b1;
      end
   end

   // Watchdog expiry; a TIMEOUT of zero turns the watchdog off entirely.
   always_comb begin
      wd_expired = (TIMEOUT != 16'd0) && (wd_cnt == (TIMEOUT - 16'd1));
   end

   // Arbitration FSM with every outward-facing signal registered. ERR is only
   // presented together with ACK, so the timeout outcome is remembered in
   // timed_out until the completion is reported.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         wd_cnt    <= '0;
         timed_out <= 1'b0;
         GRANT     <= '0;
         ACK       <= '0;
         ERR       <= 1'b0;
         TX_ADDR   <= '0;
         TX_DATA   <= '0;
         TX_REQ    <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  owner     <= sel_idx;
                  GRANT     <= sel_onehot;
                  TX_ADDR   <= sel_addr;
                  TX_DATA   <= sel_data;
                  TX_REQ    <= 1'b1;
                  wd_cnt    <= '0;
                  timed_out <= 1'b0;
                  BUSY      <= 1'b1;
                  state     <= WAIT_ACK;
               end
            end

            WAIT_ACK: begin
               if (TX_ACK) begin
                  TX_REQ    <= 1'b0;
                  timed_out <= 1'b0;
                  state     <= WAIT_REL;
               end else if (wd_expired) begin
                  TX_REQ    <= 1'b0;
                  timed_out <= 1'b1;
                  state     <= WAIT_REL;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
            end

            WAIT_REL: begin
               if (!TX_ACK) begin
                  ACK   <= owner_onehot;
                  ERR   <= timed_out;
                  state <= DONE;
               end
            end

            DONE: begin
               if (!owner_req) begin
                  ACK    <= '0;
                  ERR    <= 1'b0;
                  GRANT  <= '0;
                  rr_ptr <= next_ptr;
                  BUSY   <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Testbench for mbus_tx_arbiter: requester and node models drive the DUT,
// a transaction-level round-robin model predicts each completion, and a
// monitor compares what the DUT reports against that prediction.
module tb_mbus_tx_arbiter;

   localparam int N   = 4;
   localparam int TMO = 8;

   localparam int R_IDLE = 0;
   localparam int R_REQ  = 1;
   localparam int R_WACK = 2;
   localparam int R_WLOW = 3;

   localparam int N_IDLE  = 0;
   localparam int N_DELAY = 1;
   localparam int N_ACKED = 2;
   localparam int N_NOACK = 3;

   // delay: node acks on the delay-th cycle of TX_REQ; 0 means never ack
   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          delay;
      bit          early;
      int          hold;
   } txn_t;

   typedef struct {
      int          idx;
      logic [7:0]  addr;
      logic [31:0] data;
      bit          err;
      int          req_len;
      int          ack_len;
   } exp_t;

   logic            clk       = 1'b0;
   logic            reset     = 1'b1;
   logic [N-1:0]    req       = '0;
   logic [8*N-1:0]  addr_flat = '0;
   logic [32*N-1:0] data_flat = '0;
   logic            tx_ack    = 1'b0;
   logic [N-1:0]    ack;
   logic            err;
   logic [N-1:0]    grant;
   logic [7:0]      tx_addr;
   logic [31:0]     tx_data;
   logic            tx_req;
   logic            busy;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_en   = 1'b0;
   int   model_rr = 0;

   txn_t batch [N][$];
   txn_t req_q [N][$];
   txn_t cur [N];
   int   rstate [N];
   int   hold_left [N];
   exp_t sb [$];
   int   node_q [$];
   int   nstate = N_IDLE;
   int   ncnt   = 0;

   mbus_tx_arbiter #(
      .NUM_REQ (N),
      .TIMEOUT (16'(TMO))
   ) dut (
      .CLK       (clk),
      .RESET     (reset),
      .REQ       (req),
      .ADDR_FLAT (addr_flat),
      .DATA_FLAT (data_flat),
      .ACK       (ack),
      .ERR       (err),
      .GRANT     (grant),
      .TX_ADDR   (tx_addr),
      .TX_DATA   (tx_data),
      .TX_REQ    (tx_req),
      .TX_ACK    (tx_ack),
      .BUSY      (busy)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Safety net so a wedged DUT can never hang the run
   initial begin
      #600000;
      $display("[TB] FAIL global_timeout: simulation did not complete, got stuck at %0t, required finish", $time);
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic txn_t makeTxn(input logic [7:0] a, input logic [31:0] d, input int dly, input bit e, input int h);
      txn_t t;
      t.addr  = a;
      t.data  = d;
      t.delay = dly;
      t.early = e;
      t.hold  = h;
      return t;
   endfunction

   function automatic bit allIdle();
      bit r = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (rstate[i] != R_IDLE || req_q[i].size() != 0) r = 1'b0;
      end
      if (sb.size() != 0) r = 1'b0;
      return r;
   endfunction

   // Requester models: raise REQ with their slice, optionally drop early once
   // granted, hold for 'hold' extra cycles after ACK, and only start the next
   // request after their ACK has gone away.
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            req[i]    = 1'b0;
            rstate[i] = R_IDLE;
            req_q[i].delete();
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            case (rstate[i])
               R_IDLE: begin
                  if (req_q[i].size() > 0) begin
                     cur[i]                 = req_q[i].pop_front();
                     addr_flat[8*i +: 8]    = cur[i].addr;
                     data_flat[32*i +: 32]  = cur[i].data;
                     hold_left[i]           = cur[i].hold;
                     req[i]                 = 1'b1;
                     rstate[i]              = R_REQ;
                  end
               end
               R_REQ: begin
                  if (grant[i]) begin
                     addr_flat[8*i +: 8]   = 8'($urandom_range(0, 255));
                     data_flat[32*i +: 32] = $urandom;
                  end
                  if (cur[i].early && grant[i]) begin
                     req[i]    = 1'b0;
                     rstate[i] = R_WACK;
                  end else if (!cur[i].early && ack[i]) begin
                     if (hold_left[i] == 0) begin
                        req[i]    = 1'b0;
                        rstate[i] = R_WLOW;
                     end else begin
                        hold_left[i] = hold_left[i] - 1;
                     end
                  end
               end
               R_WACK: begin
                  if (ack[i]) rstate[i] = R_WLOW;
               end
               default: begin
                  if (!ack[i]) rstate[i] = R_IDLE;
               end
            endcase
         end
      end
   end

   // Node model: acks after the planned number of cycles (or never) and
   // releases its ack once TX_REQ has dropped.
   always @(negedge clk) begin
      if (reset) begin
         tx_ack = 1'b0;
         nstate = N_IDLE;
         node_q.delete();
      end else begin
         case (nstate)
            N_IDLE: begin
               if (tx_req) begin
                  if (node_q.size() == 0) begin
                     checkOutput("node_unplanned_request", 32'(node_q.size()), 32'd1);
                     nstate = N_NOACK;
                  end else begin
                     ncnt = node_q.pop_front();
                     if (ncnt == 0) begin
                        nstate = N_NOACK;
                     end else begin
                        ncnt = ncnt - 1;
                        if (ncnt == 0) begin
                           tx_ack = 1'b1;
                           nstate = N_ACKED;
                        end else begin
                           nstate = N_DELAY;
                        end
                     end
                  end
               end
            end
            N_DELAY: begin
               ncnt = ncnt - 1;
               if (ncnt == 0) begin
                  tx_ack = 1'b1;
                  nstate = N_ACKED;
               end
            end
            N_ACKED: begin
               if (!tx_req) begin
                  tx_ack = 1'b0;
                  nstate = N_IDLE;
               end
            end
            default: begin
               if (!tx_req) nstate = N_IDLE;
            end
         endcase
      end
   end

   // Monitor: on each new TX_REQ and each ACK pulse, compare against the
   // head of the scoreboard; retire the entry when the ACK pulse ends.
   bit prev_tx_req = 1'b0;
   bit prev_ack    = 1'b0;
   int req_cnt     = 0;
   int req_len     = 0;
   int ack_cnt     = 0;

   always @(negedge clk) begin
      if (reset || !mon_en) begin
         prev_tx_req = 1'b0;
         prev_ack    = 1'b0;
         req_cnt     = 0;
         req_len     = 0;
         ack_cnt     = 0;
      end else begin
         if (tx_req) req_cnt++;
         if (tx_req && !prev_tx_req) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_grant", 32'(grant), 32'd0);
            end else begin
               checkOutput("grant_at_tx_req", 32'(grant), 32'd1 << sb[0].idx);
               checkOutput("tx_addr_at_tx_req", 32'(tx_addr), 32'(sb[0].addr));
               checkOutput("tx_data_at_tx_req", tx_data, sb[0].data);
            end
         end
         if (!tx_req && prev_tx_req) begin
            req_len = req_cnt;
            req_cnt = 0;
         end
         if (ack != '0 && !prev_ack) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               checkOutput("ack_onehot", 32'(ack), 32'd1 << sb[0].idx);
               checkOutput("err_flag", 32'(err), 32'(sb[0].err));
               checkOutput("grant_during_ack", 32'(grant), 32'd1 << sb[0].idx);
               checkOutput("tx_addr_held", 32'(tx_addr), 32'(sb[0].addr));
               checkOutput("tx_data_held", tx_data, sb[0].data);
               checkOutput("tx_req_cycles", 32'(req_len), 32'(sb[0].req_len));
            end
         end
         if (ack != '0) ack_cnt++;
         if (ack == '0 && prev_ack) begin
            if (sb.size() != 0) begin
               checkOutput("ack_cycles", 32'(ack_cnt), 32'(sb[0].ack_len));
               checkOutput("grant_cleared_after_ack", 32'(grant), 32'd0);
               void'(sb.pop_front());
            end
            ack_cnt = 0;
         end
         prev_tx_req = tx_req;
         prev_ack    = (ack != '0);
      end
   end

   task automatic doReset();
      mon_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      reset    = 1'b0;
      model_rr = 0;
      sb.delete();
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   // Reference model: every requester with work left is requesting whenever
   // the arbiter is idle, so completions follow plain round-robin over the
   // per-requester transaction lists.
   task automatic planBatch();
      int   rem [N];
      int   pos [N];
      int   pick;
      txn_t t;
      exp_t x;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         rem[i] = batch[i].size();
         pos[i] = 0;
      end
      for (int n = 0; n < 64; n++) begin
         pick = -1;
         for (int k = N - 1; k >= 0; k--) begin
            if (rem[(model_rr + k) % N] > 0) pick = (model_rr + k) % N;
         end
         if (pick >= 0) begin
            t         = batch[pick][pos[pick]];
            pos[pick] = pos[pick] + 1;
            rem[pick] = rem[pick] - 1;
            x.idx     = pick;
            x.addr    = t.addr;
            x.data    = t.data;
            x.err     = (t.delay == 0);
            x.req_len = (t.delay == 0) ? TMO : t.delay;
            x.ack_len = t.early ? 1 : t.hold + 1;
            sb.push_back(x);
            node_q.push_back(t.delay);
            model_rr  = (pick + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) begin
         foreach (batch[i][j]) req_q[i].push_back(batch[i][j]);
         batch[i].delete();
      end
   endtask

   task automatic waitDone();
      int cyc = 0;
      while (!allIdle() && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("batch_completed", 32'(allIdle()), 32'd1);
      checkOutput("node_queue_drained", 32'(node_q.size()), 32'd0);
      if (!allIdle()) doReset();
      repeat (2) @(negedge clk);
   endtask

   task automatic applyStimulus();
      planBatch();
      waitDone();
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < N; i++) rstate[i] = R_IDLE;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_ack", 32'(ack), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      checkOutput("reset_grant", 32'(grant), 32'd0);
      checkOutput("reset_tx_addr", 32'(tx_addr), 32'd0);
      checkOutput("reset_tx_data", tx_data, 32'd0);
      checkOutput("reset_tx_req", 32'(tx_req), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      reset    = 1'b0;
      model_rr = 0;
      @(negedge clk);
      mon_en = 1'b1;

      // Fairness: everyone requesting twice, expected order 0,1,2,3,0,1,2,3
      $display("[TB] round-robin fairness");
      for (int i = 0; i < N; i++) begin
         for (int c = 0; c < 2; c++) begin
            batch[i].push_back(makeTxn(8'($urandom_range(0, 255)), $urandom, 2, 1'b0, 0));
         end
      end
      applyStimulus();

      // Single request with request-to-TX_REQ latency
      $display("[TB] single request");
      batch[1].push_back(makeTxn(8'hab, 32'hDEADBEEF, 3, 1'b0, 0));
      planBatch();
      @(negedge clk);
      #1;
      checkOutput("single_req_raised", 32'(req[1]), 32'd1);
      checkOutput("single_tx_req_not_yet", 32'(tx_req), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("single_tx_req_latency", 32'(tx_req), 32'd1);
      checkOutput("single_busy", 32'(busy), 32'd1);
      waitDone();

      // Timeout on requester 2, then requester 3 still gets served
      $display("[TB] watchdog timeout");
      batch[2].push_back(makeTxn(8'h22, 32'h2222_0000, 0, 1'b0, 0));
      batch[3].push_back(makeTxn(8'h33, 32'h3333_0000, 2, 1'b0, 1));
      applyStimulus();

      // Ack arriving on the very cycle the watchdog would expire
      $display("[TB] timeout/ack collision");
      batch[0].push_back(makeTxn(8'h0c, 32'hC011_1DE0, TMO, 1'b0, 0));
      applyStimulus();

      // Requester drops REQ while the node is still working
      $display("[TB] early release");
      batch[1].push_back(makeTxn(8'h1e, 32'hEA41_7E1E, 4, 1'b1, 0));
      applyStimulus();

      // Randomized batches
      $display("[TB] random batches");
      for (int b = 0; b < 25; b++) begin
         for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = int'($urandom_range(0, 2));
            for (int c = 0; c < cnt; c++) begin
               batch[i].push_back(makeTxn(8'($urandom_range(0, 255)), $urandom,
                                          int'($urandom_range(0, TMO)),
                                          ($urandom_range(0, 3) == 0),
                                          int'($urandom_range(0, 2))));
            end
         end
         applyStimulus();
      end

      // Reset in the middle of a transfer, with rr_ptr parked at 3 first
      $display("[TB] reset mid-transfer");
      batch[2].push_back(makeTxn(8'h20, 32'h0000_2020, 2, 1'b0, 0));
      applyStimulus();
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      node_q.push_back(0);
      req_q[0].push_back(makeTxn(8'h5a, 32'h5A5A_5A5A, 0, 1'b0, 0));
      cyc = 0;
      while (tx_req !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("abort_setup_tx_req", 32'(tx_req), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("abort_tx_req", 32'(tx_req), 32'd0);
      checkOutput("abort_grant", 32'(grant), 32'd0);
      checkOutput("abort_ack", 32'(ack), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_err", 32'(err), 32'd0);
      @(negedge clk);
      #1;
      reset    = 1'b0;
      model_rr = 0;
      @(negedge clk);
      mon_en = 1'b1;
      batch[0].push_back(makeTxn(8'h01, 32'h0000_0001, 2, 1'b0, 0));
      batch[3].push_back(makeTxn(8'h03, 32'h0000_0003, 2, 1'b0, 0));
      applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
